// File: rtl/atm_ledger_arbiter_pkg.sv
// Shared constants for the ATM ledger arbiter: op codes, FSM state encoding and default widths.
package atm_pkg;

  localparam int DEFAULT_BALANCE_W = 20;
  localparam int DEFAULT_ACCT_W    = 4;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_WITHDRAW = 2'b00;
  localparam op_t OP_DEPOSIT  = 2'b01;
  localparam op_t OP_BALANCE  = 2'b10;
  localparam op_t OP_RSVD     = 2'b11;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_CALC = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage

// File: rtl/atm_ledger_arbiter_rr_arbiter.sv
// Rotating-priority pick: first requester at or above the pointer, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_ATM = 4,
  parameter int IDX_W   = (NUM_ATM > 1) ? $clog2(NUM_ATM) : 1
) (
  input  logic [NUM_ATM-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [NUM_ATM-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_ATM);

  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] pos_s;

  // ptr_i < NUM_ATM and k < NUM_ATM, so one conditional subtract is a full modulo
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    pos_s   = '0;
    for (int k = 0; k < NUM_ATM; k++) begin
      cand_s = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand_s >= N_W) begin
        cand_s = cand_s - N_W;
      end else begin
        cand_s = cand_s;
      end
      pos_s = cand_s[IDX_W-1:0];
      if (!valid_o && req_i[pos_s]) begin
        valid_o = 1'b1;
        idx_o   = pos_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

  always_comb begin
    onehot_o = '0;
    if (valid_o) begin
      onehot_o[idx_o] = 1'b1;
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter sharing one single-port ledger RAM between ATM terminals;
// each grant runs an atomic 4-cycle read-modify-write (IDLE, READ, CALC, RESP).
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_ATM   = 4,
  parameter int BALANCE_W = DEFAULT_BALANCE_W,
  parameter int ACCT_W    = DEFAULT_ACCT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_ATM-1:0]            req,
  input  logic [2*NUM_ATM-1:0]          op,
  input  logic [ACCT_W*NUM_ATM-1:0]     acct,
  input  logic [BALANCE_W*NUM_ATM-1:0]  value,
  output logic [NUM_ATM-1:0]            gnt,
  output logic                          busy,
  output logic                          done,
  output logic [BALANCE_W-1:0]          rsp_balance,
  output logic                          rsp_error,
  output logic [ACCT_W-1:0]             mem_addr,
  output logic                          mem_rd_en,
  input  logic [BALANCE_W-1:0]          mem_rdata,
  output logic                          mem_wr_en,
  output logic [BALANCE_W-1:0]          mem_wdata
);

  localparam int               IDX_W    = (NUM_ATM > 1) ? $clog2(NUM_ATM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ATM - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_ATM-1:0]     gnt_q, gnt_d;
  logic                   done_q, done_d;
  logic [BALANCE_W-1:0]   rsp_balance_q, rsp_balance_d;
  logic                   rsp_error_q, rsp_error_d;
  op_t                    op_q, op_d;
  logic [ACCT_W-1:0]      acct_q, acct_d;
  logic [BALANCE_W-1:0]   value_q, value_d;

  logic                   win_valid_s;
  logic [NUM_ATM-1:0]     win_onehot_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic [BALANCE_W:0]     sum_s;
  logic                   wr_ok_s;
  logic                   calc_err_s;
  logic [BALANCE_W-1:0]   calc_res_s;

  rr_arbiter #(
    .NUM_ATM (NUM_ATM),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (win_valid_s),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s)
  );

  // Deposit sum carries one extra bit so overflow is a simple carry test
  always_comb begin
    sum_s      = {1'b0, mem_rdata} + {1'b0, value_q};
    wr_ok_s    = 1'b0;
    calc_err_s = 1'b0;
    calc_res_s = mem_rdata;
    case (op_q)
      OP_WITHDRAW: begin
        if (value_q > mem_rdata) begin
          calc_err_s = 1'b1;
        end else begin
          wr_ok_s    = 1'b1;
          calc_res_s = mem_rdata - value_q;
        end
      end
      OP_DEPOSIT: begin
        if (sum_s[BALANCE_W]) begin
          calc_err_s = 1'b1;
        end else begin
          wr_ok_s    = 1'b1;
          calc_res_s = sum_s[BALANCE_W-1:0];
        end
      end
      OP_BALANCE: calc_err_s = 1'b0;
      default:    calc_err_s = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    done_d        = 1'b0;
    rsp_balance_d = rsp_balance_q;
    rsp_error_d   = rsp_error_q;
    op_d          = op_q;
    acct_d        = acct_q;
    value_d       = value_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_d = ST_READ;
          gnt_d   = win_onehot_s;
          ptr_d   = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + IDX_W'(1);
          op_d    = op[int'(win_idx_s)*2 +: 2];
          acct_d  = acct[int'(win_idx_s)*ACCT_W +: ACCT_W];
          value_d = value[int'(win_idx_s)*BALANCE_W +: BALANCE_W];
        end else begin
          gnt_d = '0;
        end
      end
      ST_READ: state_d = ST_CALC;
      ST_CALC: begin
        state_d       = ST_RESP;
        done_d        = 1'b1;
        rsp_balance_d = calc_res_s;
        rsp_error_d   = calc_err_s;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      done_q        <= 1'b0;
      rsp_balance_q <= '0;
      rsp_error_q   <= 1'b0;
      op_q          <= OP_WITHDRAW;
      acct_q        <= '0;
      value_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rsp_balance_q <= rsp_balance_d;
      rsp_error_q   <= rsp_error_d;
      op_q          <= op_d;
      acct_q        <= acct_d;
      value_q       <= value_d;
    end
  end

  // Memory strobes decode from the state so reset drops them immediately
  assign gnt         = gnt_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign rsp_balance = rsp_balance_q;
  assign rsp_error   = rsp_error_q;
  assign mem_rd_en   = (state_q == ST_READ);
  assign mem_wr_en   = (state_q == ST_CALC) && wr_ok_s;
  assign mem_addr    = ((state_q == ST_READ) || (state_q == ST_CALC)) ? acct_q : '0;
  assign mem_wdata   = mem_wr_en ? calc_res_s : '0;

endmodule

// File: doc/atm_ledger_arbiter.md
Name: atm_ledger_arbiter

Overview:
- Shares one account-balance memory between NUM_ATM ATM terminal FSMs.
- Round-robin arbitration; the granted transaction (withdraw / deposit / inquiry) runs as an atomic read-modify-write.
- Sits between the terminal FSMs and the single-port ledger RAM.
- Returns the resulting balance and an error flag to the winning terminal.

Parameters:
- NUM_ATM, 4, number of requesting terminals (2..8).
- BALANCE_W, 20, balance and value width in bits.
- ACCT_W, 4, account index width (2^ACCT_W accounts).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_ATM  per-terminal transaction request; held high until done.
- op  in  2*NUM_ATM  per-terminal op; slice i = op[2i+1:2i]: withdraw 00, deposit 01, balance 10, 11 reserved.
- acct  in  ACCT_W*NUM_ATM  per-terminal account index, sliced the same way.
- value  in  BALANCE_W*NUM_ATM  per-terminal amount, sliced the same way.
- gnt  out  NUM_ATM  one-hot grant, registered.
- busy  out  1  a transaction is in progress (state != IDLE).
- done  out  1  one-cycle completion pulse, registered.
- rsp_balance  out  BALANCE_W  balance after the transaction; valid while done=1.
- rsp_error  out  1  transaction rejected; valid while done=1.
- mem_addr  out  ACCT_W  ledger address.
- mem_rd_en  out  1  ledger read strobe.
- mem_rdata  in  BALANCE_W  ledger read data, valid one cycle after mem_rd_en.
- mem_wr_en  out  1  ledger write strobe.
- mem_wdata  out  BALANCE_W  ledger write data.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rr pointer=0.
- Reset values of outputs and latched fields: gnt=0, busy=0, done=0, rsp_balance=0, rsp_error=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0; latched op/acct/value cleared.
- Ledger RAM contents are not reset.
- FSM states: IDLE -> READ -> CALC -> RESP -> IDLE. No stalls; every granted transaction takes exactly 4 cycles.
- IDLE:
  - If any req bit is high, select the winner: first set req bit searching upward from the rr pointer, wrapping NUM_ATM-1 -> 0.
  - Latch the winner's op/acct/value; register gnt=onehot(winner); pointer <= winner+1 (mod NUM_ATM); go to READ.
  - If no req, stay in IDLE with gnt=0.
- READ: mem_addr=latched acct, mem_rd_en=1. Go to CALC.
- CALC (mem_rdata valid, bal=mem_rdata):
  - withdraw: if value > bal, error=1, no write, result=bal. Otherwise mem_wr_en=1, mem_wdata=bal-value, result=bal-value.
  - deposit: sum is computed at BALANCE_W+1 bits. If sum > 2^BALANCE_W-1, error=1, no write, result=bal. Otherwise write sum, result=sum.
  - balance: no write, result=bal, error=0.
  - op 11: error=1, no write, result=bal.
  - value=0 is legal; the write still occurs with an unchanged value.
  - Register result into rsp_balance and error into rsp_error. Go to RESP.
- RESP: done=1, gnt held. Next cycle: IDLE, gnt=0, done=0.
- mem_rd_en, mem_addr and mem_wr_en decode from the state register. mem_wdata is combinational from mem_rdata in CALC.
- Grant duration: gnt stays asserted from READ through RESP inclusive (3 cycles).
- Latency: req sampled in IDLE at cycle t -> done at t+3. Back-to-back grants are possible from t+4.
- Atomicity: a winner dropping req mid-transaction (terminal timeout) does not abort it. The write and done still occur, so the ledger stays consistent.
- Inputs of non-granted terminals are ignored until they win.
- Fairness: with all req high continuously, grants rotate 0,1,2,3,0,...; no terminal waits more than NUM_ATM-1 transactions.
- A terminal re-requesting in the IDLE cycle right after its own RESP loses to any other pending requester.
- Two terminals on the same account are serialized; the second sees the first's result.
- Reset mid-operation: if asserted in CALC, the write either completed on the prior edge or never occurs. No partial state; all outputs return to reset values immediately.

Decomposition:
- Shared package atm_pkg holds:
  - op codes OP_WITHDRAW=2'b00, OP_DEPOSIT=2'b01, OP_BALANCE=2'b10, OP_RSVD=2'b11;
  - arbiter state encoding (IDLE, READ, CALC, RESP);
  - default widths BALANCE_W=20, ACCT_W=4.
- One sub-module, rr_arbiter: combinational rotating-priority pick from req and pointer, producing a one-hot winner and its index.

Test Plan:
- Single withdraw: ATM0, acct 3 holds 500, value 200 -> gnt=0001 for 3 cycles; mem write 300 to addr 3; done at t+3 with rsp_balance=300, rsp_error=0.
- Overdraft: acct 3 holds 100, withdraw 150 -> no mem_wr_en; rsp_balance=100, rsp_error=1.
- Deposit overflow: acct 5 holds 0xFFFF0, deposit 0x20 -> no write, rsp_error=1, rsp_balance=0xFFFF0. Then deposit 0xF -> balance 0xFFFFF, no error.
- Round-robin: all four req high, each depositing 10 to acct 1 (start 0) -> grant order 0,1,2,3; rsp_balance 10,20,30,40; done pulses 4 cycles apart.
- Abort: ATM2 withdraws 50 from 80, req dropped in CALC -> write of 30 still occurs and done pulses; a following balance inquiry returns 30.
- Reset in CALC: rst pulse -> gnt, busy, done and mem strobes go to 0 immediately; pointer returns to 0; next request from ATM1 with ATM0 also requesting grants ATM0 first.
